inter_packet_delay_gen2: RTL and testbench



---
 rtl/inter_packet_delay_gen2.sv | 161 ++++++++++++++++
 tb/tb_inter_packet_delay_gen2.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inter_packet_delay_gen2.sv
// inter_packet_delay_gen2: enforces a programmable idle gap between AXI4-Stream
// packets. The stream passes through combinationally with zero latency; only the
// head beat of each packet can be held off until the gap counter reaches the
// effective delay. The delay comes from a register, from a tuser field, or from
// their saturating sum.
// Optional statistics counters are built when INTER_PACKET_DELAY_STATS_EN is
// defined.
module inter_packet_delay_gen2 #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_DELAY_WIDTH        = 32,
    parameter int C_TUSER_DELAY_OFFSET = 32
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_aresetn,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    input  logic                                 sw_rst,
    input  logic                                 ipd_en,
    input  logic [1:0]                           delay_mode,
    input  logic [C_DELAY_WIDTH-1:0]             delay_reg_val
`ifdef INTER_PACKET_DELAY_STATS_EN
    ,
    output logic [31:0]                          pkt_cnt,
    output logic [31:0]                          stall_cnt
`endif
);

    typedef enum logic [0:0] {ST_IDLE, ST_PASS} state_t;

    localparam logic [C_DELAY_WIDTH-1:0] DELAY_MAX = {C_DELAY_WIDTH{1'b1}};

    state_t                   r_state;
    state_t                   w_state_next;
    logic [C_DELAY_WIDTH-1:0] r_gap_cnt;
    logic [C_DELAY_WIDTH-1:0] w_tuser_delay;
    logic [C_DELAY_WIDTH:0]   w_delay_sum;
    logic [C_DELAY_WIDTH-1:0] w_delay_eff;
    logic                     w_release;
    logic                     w_active;
    logic                     w_m_tvalid;
    logic                     w_s_tready;
    logic                     w_hs;

    // Zero-latency datapath
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tstrb  = s_axis_tstrb;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = w_m_tvalid;
    assign s_axis_tready = w_s_tready;

    // Handshakes are suppressed while either reset is active
    assign w_active = axi_aresetn & ~sw_rst;
    assign w_hs     = w_m_tvalid & m_axis_tready;

    assign w_tuser_delay = s_axis_tuser[C_TUSER_DELAY_OFFSET +: C_DELAY_WIDTH];
    assign w_delay_sum   = {1'b0, delay_reg_val} + {1'b0, w_tuser_delay};

    // Effective delay for the waiting head beat; mode 3 falls back to the register
    always_comb begin
        w_delay_eff = delay_reg_val;
        case (delay_mode)
            2'b01:   w_delay_eff = w_tuser_delay;
            2'b10:   w_delay_eff = w_delay_sum[C_DELAY_WIDTH] ? DELAY_MAX
                                                              : w_delay_sum[C_DELAY_WIDTH-1:0];
            default: w_delay_eff = delay_reg_val;
        endcase
    end

    assign w_release = ~ipd_en | (r_gap_cnt >= w_delay_eff);

    // State register; soft reset returns to IDLE so the next beat is a head
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state <= ST_IDLE;
        end else if (sw_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake gating: only the head beat is ever held off
    always_comb begin
        w_state_next = r_state;
        w_m_tvalid   = 1'b0;
        w_s_tready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_m_tvalid = w_active & s_axis_tvalid & w_release;
                w_s_tready = w_active & m_axis_tready & w_release;
                if (w_m_tvalid && m_axis_tready && !s_axis_tlast) begin
                    w_state_next = ST_PASS;
                end
            end
            ST_PASS: begin
                w_m_tvalid = w_active & s_axis_tvalid;
                w_s_tready = w_active & m_axis_tready;
                if (w_m_tvalid && m_axis_tready && s_axis_tlast) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Gap counter: cleared by the last beat, then counts up to saturation
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_gap_cnt <= DELAY_MAX;
        end else if (sw_rst) begin
            r_gap_cnt <= DELAY_MAX;
        end else if (w_hs && s_axis_tlast) begin
            r_gap_cnt <= '0;
        end else if (r_gap_cnt != DELAY_MAX) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

`ifdef INTER_PACKET_DELAY_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_stall_cnt;

    assign pkt_cnt   = r_pkt_cnt;
    assign stall_cnt = r_stall_cnt;

    // Packet and stall statistics, free-running with natural wrap
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (sw_rst) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && w_hs) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (r_state == ST_IDLE && s_axis_tvalid && !w_release) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inter_packet_delay_gen2.sv
// Directed testbench for inter_packet_delay_gen2. A second instance with a
// 4-bit delay width exercises saturation of the reg+tuser sum.
module tb_inter_packet_delay_gen2;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         sw_rst;
    logic         ipd_en;
    logic [1:0]   mode;
    logic [31:0]  reg_val;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid;
    logic         s_tlast;
    logic         m_tready;

    logic [255:0] m1_tdata;
    logic [31:0]  m1_tstrb;
    logic [127:0] m1_tuser;
    logic         m1_tvalid;
    logic         m1_tlast;
    logic         s1_tready;

    logic [31:0]  m2_tdata;
    logic [3:0]   m2_tstrb;
    logic [63:0]  m2_tuser;
    logic         m2_tvalid;
    logic         m2_tlast;
    logic         s2_tready;

    logic         sel2 = 1'b0;
    int           checks = 0;
    int           errors = 0;

`ifdef INTER_PACKET_DELAY_STATS_EN
    logic [31:0]  pkt1, stall1, pkt2, stall2;
`endif

    inter_packet_delay_gen2 u_dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .m_axis_tdata  (m1_tdata),
        .m_axis_tstrb  (m1_tstrb),
        .m_axis_tuser  (m1_tuser),
        .m_axis_tvalid (m1_tvalid),
        .m_axis_tlast  (m1_tlast),
        .m_axis_tready (m_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s1_tready),
        .sw_rst        (sw_rst),
        .ipd_en        (ipd_en),
        .delay_mode    (mode),
        .delay_reg_val (reg_val)
`ifdef INTER_PACKET_DELAY_STATS_EN
        ,
        .pkt_cnt       (pkt1),
        .stall_cnt     (stall1)
`endif
    );

    inter_packet_delay_gen2 #(
        .C_M_AXIS_DATA_WIDTH  (32),
        .C_S_AXIS_DATA_WIDTH  (32),
        .C_M_AXIS_TUSER_WIDTH (64),
        .C_S_AXIS_TUSER_WIDTH (64),
        .C_DELAY_WIDTH        (4),
        .C_TUSER_DELAY_OFFSET (32)
    ) u_dut4 (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .m_axis_tdata  (m2_tdata),
        .m_axis_tstrb  (m2_tstrb),
        .m_axis_tuser  (m2_tuser),
        .m_axis_tvalid (m2_tvalid),
        .m_axis_tlast  (m2_tlast),
        .m_axis_tready (m_tready),
        .s_axis_tdata  (s_tdata[31:0]),
        .s_axis_tstrb  (s_tstrb[3:0]),
        .s_axis_tuser  (s_tuser[63:0]),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s2_tready),
        .sw_rst        (sw_rst),
        .ipd_en        (ipd_en),
        .delay_mode    (mode),
        .delay_reg_val (reg_val[3:0])
`ifdef INTER_PACKET_DELAY_STATS_EN
        ,
        .pkt_cnt       (pkt2),
        .stall_cnt     (stall2)
`endif
    );

    // Present one beat and hold it until accepted; reports cycles spent waiting
    task automatic send_beat(input logic last, input logic [31:0] fld,
                             input logic [7:0] tag, output int waited);
        logic rdy;
        waited   = 0;
        s_tvalid = 1'b1;
        s_tlast  = last;
        s_tdata  = {32{tag}};
        s_tstrb  = '1;
        s_tuser  = {64'h0, fld, 24'h0, tag};
        forever begin
            @(negedge clk);
            rdy = sel2 ? s2_tready : s1_tready;
            if (rdy) break;
            waited++;
            if (waited > 300) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout tag=%0h: no handshake after %0d cycles, required within 300",
                         tag, waited);
                break;
            end
        end
        $display("beat tag=%0h last=%0b waited=%0d", tag, last, waited);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sw_rst();
        s_tvalid = 1'b0;
        sw_rst   = 1'b1;
        @(posedge clk);
        #1;
        sw_rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        sw_rst   = 1'b0;
        ipd_en   = 1'b1;
        mode     = 2'b00;
        reg_val  = 32'd0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = '0;
        s_tstrb  = '1;
        s_tuser  = '0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m1_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid got=%b exp=0", m1_tvalid);
        end
        checks++;
        if (s1_tready !== 1'b0) begin
            errors++; $display("FAIL reset_tready got=%b exp=0", s1_tready);
        end
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m1_tvalid !== 1'b0) begin
            errors++; $display("FAIL idle_tvalid got=%b exp=0", m1_tvalid);
        end
        checks++;
        if (s1_tready !== 1'b1) begin
            errors++; $display("FAIL idle_tready got=%b exp=1", s1_tready);
        end
`ifdef INTER_PACKET_DELAY_STATS_EN
        checks++;
        if (pkt1 !== 32'd0 || stall1 !== 32'd0) begin
            errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", pkt1, stall1);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    // Register delay 3 between 2-beat packets
    task automatic test_mode_reg();
        int w0, w1, exp0;
        mode    = 2'b00;
        reg_val = 32'd3;
        ipd_en  = 1'b1;
        for (int p = 0; p < 3; p++) begin
            send_beat(1'b0, 32'd0, 8'h10 + 8'(p), w0);
            send_beat(1'b1, 32'd0, 8'h18 + 8'(p), w1);
            exp0 = (p == 0) ? 0 : 3;
            checks++;
            if (w0 !== exp0) begin
                errors++; $display("FAIL reg_head_wait pkt=%0d got=%0d exp=%0d", p, w0, exp0);
            end
            checks++;
            if (w1 !== 0) begin
                errors++; $display("FAIL reg_tail_wait pkt=%0d got=%0d exp=0", p, w1);
            end
        end
        s_tvalid = 1'b0;
    endtask

    // Per-packet delay from tuser, then mode 3 falling back to the register
    task automatic test_mode_tuser();
        int w;
        int flds [3] = '{0, 5, 1};
        mode = 2'b01;
        for (int p = 0; p < 3; p++) begin
            send_beat(1'b1, flds[p], 8'h20 + 8'(p), w);
            checks++;
            if (w !== flds[p]) begin
                errors++; $display("FAIL tuser_wait pkt=%0d got=%0d exp=%0d", p, w, flds[p]);
            end
        end
        mode    = 2'b11;
        reg_val = 32'd2;
        send_beat(1'b1, 32'd7, 8'h23, w);
        checks++;
        if (w !== 2) begin
            errors++; $display("FAIL mode3_wait got=%0d exp=2", w);
        end
        s_tvalid = 1'b0;
    endtask

    // Gating disabled, then enabled mid-packet
    task automatic test_ipd_disable();
        int w;
        logic [255:0] exp_data;
        logic [127:0] exp_user;
        exp_data = {8{32'hDEADBEEF}};
        exp_user = {32'h0, 32'hCAFE0001, 32'd100, 32'h5};
        mode     = 2'b00;
        reg_val  = 32'd100;
        ipd_en   = 1'b0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tdata  = exp_data;
        s_tuser  = exp_user;
        @(negedge clk);
        checks++;
        if (m1_tvalid !== 1'b1) begin
            errors++; $display("FAIL pass_tvalid got=%b exp=1", m1_tvalid);
        end
        checks++;
        if (m1_tdata !== exp_data) begin
            errors++; $display("FAIL pass_tdata got=%h exp=%h", m1_tdata, exp_data);
        end
        checks++;
        if (m1_tuser !== exp_user || m1_tlast !== 1'b0) begin
            errors++; $display("FAIL pass_tuser got=%h/%b exp=%h/0", m1_tuser, m1_tlast, exp_user);
        end
        $display("beat tag=data last=0 waited=0");
        @(posedge clk);
        #1;
        send_beat(1'b1, 32'd0, 8'h30, w);
        for (int p = 0; p < 2; p++) begin
            send_beat(1'b0, 32'd0, 8'h31, w);
            checks++;
            if (w !== 0) begin
                errors++; $display("FAIL disabled_wait pkt=%0d got=%0d exp=0", p, w);
            end
            send_beat(1'b1, 32'd0, 8'h32, w);
        end
        send_beat(1'b0, 32'd0, 8'h33, w);
        ipd_en = 1'b1;
        send_beat(1'b1, 32'd0, 8'h34, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL enable_midpkt_wait got=%0d exp=0", w);
        end
        send_beat(1'b1, 32'd0, 8'h35, w);
        checks++;
        if (w !== 100) begin
            errors++; $display("FAIL enable_next_wait got=%0d exp=100", w);
        end
        s_tvalid = 1'b0;
    endtask

    // Downstream stall does not stretch the gap
    task automatic test_backpressure();
        int w;
        logic exp_v;
        mode    = 2'b00;
        reg_val = 32'd4;
        send_beat(1'b1, 32'd0, 8'h40, w);
        checks++;
        if (w !== 4) begin
            errors++; $display("FAIL bp_first_wait got=%0d exp=4", w);
        end
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = {32{8'h41}};
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            exp_v = (i >= 5);
            checks++;
            if (m1_tvalid !== exp_v) begin
                errors++; $display("FAIL bp_tvalid cycle=%0d got=%b exp=%b", i, m1_tvalid, exp_v);
            end
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        send_beat(1'b1, 32'd0, 8'h41, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL bp_release_wait got=%0d exp=0", w);
        end
        s_tvalid = 1'b0;
    endtask

    // Soft reset mid-packet and hard reset while a head beat waits
    task automatic test_sw_rst();
        int w;
        send_beat(1'b0, 32'd0, 8'h50, w);
        checks++;
        if (w !== 4) begin
            errors++; $display("FAIL swrst_head_wait got=%0d exp=4", w);
        end
        send_beat(1'b0, 32'd0, 8'h51, w);
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        sw_rst   = 1'b1;
        @(negedge clk);
        checks++;
        if (m1_tvalid !== 1'b0 || s1_tready !== 1'b0) begin
            errors++; $display("FAIL swrst_gate got=%b/%b exp=0/0", m1_tvalid, s1_tready);
        end
        @(posedge clk);
        #1;
        sw_rst = 1'b0;
        send_beat(1'b1, 32'd0, 8'h52, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL swrst_after_wait got=%0d exp=0", w);
        end
        send_beat(1'b1, 32'd0, 8'h53, w);
        checks++;
        if (w !== 4) begin
            errors++; $display("FAIL swrst_next_wait got=%0d exp=4", w);
        end
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        @(negedge clk);
        checks++;
        if (m1_tvalid !== 1'b0) begin
            errors++; $display("FAIL held_head_tvalid got=%b exp=0", m1_tvalid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m1_tvalid !== 1'b0 || s1_tready !== 1'b0) begin
            errors++; $display("FAIL rst_wait_gate got=%b/%b exp=0/0", m1_tvalid, s1_tready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_beat(1'b1, 32'd0, 8'h54, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL rst_after_wait got=%0d exp=0", w);
        end
        s_tvalid = 1'b0;
    endtask

    // Saturated source of 10 single-beat packets with delay 3
    task automatic test_back_to_back();
        int w, expw;
        pulse_sw_rst();
        mode    = 2'b00;
        reg_val = 32'd3;
        for (int p = 0; p < 10; p++) begin
            send_beat(1'b1, 32'd0, 8'h60 + 8'(p), w);
            expw = (p == 0) ? 0 : 3;
            checks++;
            if (w !== expw) begin
                errors++; $display("FAIL b2b_wait pkt=%0d got=%0d exp=%0d", p, w, expw);
            end
        end
        s_tvalid = 1'b0;
`ifdef INTER_PACKET_DELAY_STATS_EN
        @(negedge clk);
        checks++;
        if (pkt1 !== 32'd10) begin
            errors++; $display("FAIL pkt_cnt got=%0d exp=10", pkt1);
        end
        checks++;
        if (stall1 !== 32'd27) begin
            errors++; $display("FAIL stall_cnt got=%0d exp=27", stall1);
        end
        @(posedge clk);
        #1;
`endif
    endtask

    // 4-bit instance: reg 2 + tuser 15 clamps to 15
    task automatic test_saturate();
        int w;
        int flds [3] = '{15, 15, 3};
        int exps [3] = '{0, 15, 5};
        sel2 = 1'b1;
        pulse_sw_rst();
        mode    = 2'b10;
        reg_val = 32'd2;
        for (int p = 0; p < 3; p++) begin
            send_beat(1'b1, flds[p], 8'h70 + 8'(p), w);
            checks++;
            if (w !== exps[p]) begin
                errors++; $display("FAIL sat_wait pkt=%0d got=%0d exp=%0d", p, w, exps[p]);
            end
        end
        s_tvalid = 1'b0;
        sel2     = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode_reg();
        test_mode_tuser();
        test_ipd_disable();
        test_backpressure();
        test_sw_rst();
        test_back_to_back();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
